mmcm_drp_reconfig_master: RTL and testbench
===========================================

// Module: mmcm_drp_reconfig_master
// PURPOSE
//  DRP initiator that reprograms one MMCME2 DRP register per request by read-modify-write.
//  Sits between the clocking control logic and the DRP/RST/LOCKED pins of MMCME2_DUMMY.
//  Sequence per request: assert MMCM reset, read the register, merge in the new bits, write it back,
//  release the reset, then wait for LOCKED. Returns the old register value and an error flag.
// PARAMETERS
//  ADDR_W          7     DRP address width
//  DATA_W          16    DRP data width
//  DRDY_TIMEOUT    64    max cycles waiting for drp_drdy (only with MMCM_DRP_TIMEOUT_EN)
//  LOCK_TIMEOUT    1024  max cycles waiting for mmcm_locked (only with MMCM_DRP_TIMEOUT_EN)
// PORTS
//  clkin_int    in   1       clock
//  reset_int    in   1       reset, asynchronous, active-high
//  req_valid    in   1       request valid
//  req_ready    out  1       request accepted when req_valid & req_ready
//  req_addr     in   ADDR_W  DRP register address
//  req_data     in   DATA_W  new field bits
//  req_mask     in   DATA_W  1 = keep old bit, 0 = take req_data bit
//  resp_valid   out  1       one-cycle completion pulse
//  resp_rdata   out  DATA_W  register value read before the write; held until next response
//  resp_err     out  1       error flag, qualified by resp_valid
//  drp_daddr    out  ADDR_W  to DADDR
//  drp_den      out  1       to DEN; one-cycle pulse
//  drp_dwe      out  1       to DWE; high only when drp_den is high
//  drp_di       out  DATA_W  to DI
//  drp_do       in   DATA_W  from DO
//  drp_drdy     in   1       from DRDY
//  mmcm_rst     out  1       to MMCM RST
//  mmcm_locked  in   1       from MMCM LOCKED
// BEHAVIOUR
//  Reset: all outputs are 0 except req_ready=1. State is IDLE.
//   Asserting reset_int mid-transaction aborts it immediately. No response is issued.
//  States and transitions:
//   IDLE: req_ready=1. On accept, latch addr/data/mask and go to ASSERT_RST.
//   ASSERT_RST: mmcm_rst=1 (held through WR_WAIT). Go to RD_REQ after 1 cycle.
//   RD_REQ: drp_den=1, drp_dwe=0, drp_daddr=addr for 1 cycle. Go to RD_WAIT.
//   RD_WAIT: on drp_drdy, capture rd=drp_do and go to WR_REQ.
//   WR_REQ: drp_den=1, drp_dwe=1, drp_di=(rd & mask) | (data & ~mask), 1 cycle. Go to WR_WAIT.
//   WR_WAIT: on drp_drdy, go to RELEASE.
//   RELEASE: mmcm_rst=0. Stay exactly 2 cycles, ignoring mmcm_locked. Go to LOCK_WAIT.
//   LOCK_WAIT: on mmcm_locked=1, go to DONE.
//   DONE: resp_valid=1 for 1 cycle, resp_rdata=rd. Go to IDLE; req_ready=1 on the next cycle.
//  drp_drdy handling:
//   - Sampled in *_REQ and *_WAIT states. A drdy seen in a REQ cycle completes that access.
//   - Ignored in all other states. A stray drdy never advances the FSM.
//  Latency with drdy one cycle after den and locked already high:
//   accept -> resp_valid = 9 cycles.
//  req_valid while busy: held off by req_ready=0. No queueing.
//  drp_daddr keeps the latched address from RD_REQ through WR_WAIT. drp_di is 0 outside WR_REQ.
//  resp_err=0 whenever no timeout occurred.
// CONFIGURATION
//  MMCM_DRP_TIMEOUT_EN defined:
//   - A cycle counter runs in RD_WAIT, WR_WAIT and LOCK_WAIT and clears on every state change.
//   - After DRDY_TIMEOUT cycles in RD_WAIT/WR_WAIT: set a sticky err, skip any remaining DRP access,
//     go to RELEASE (reset is always released).
//   - After LOCK_TIMEOUT cycles in LOCK_WAIT: set err, go to DONE.
//   - resp_err = err. err is cleared on the next request accept.
//  MMCM_DRP_TIMEOUT_EN undefined:
//   - No counter. All waits are unbounded. resp_err is tied to 0.
// TESTING
//  1. Old=16'h1234, addr=7'h08, data=16'h00AB, mask=16'hFF00, drdy 1 cycle after den, locked=1
//     -> drp_di=16'h12AB with dwe=1, resp_rdata=16'h1234, resp_err=0, resp_valid 9 cycles after accept.
//  2. drdy delayed 5 cycles for both the read and the write
//     -> den pulses stay 1 cycle, mmcm_rst high throughout both accesses, resp_valid at cycle 17.
//  3. locked held low for 20 cycles after release
//     -> resp_valid 1 cycle after locked rises; req_ready=0 for the whole transaction.
//  4. reset_int pulsed during RD_WAIT
//     -> all outputs reset within the same cycle, no resp_valid; next request completes normally.
//  5. drdy never returns: with MMCM_DRP_TIMEOUT_EN, DRDY_TIMEOUT=64 -> no write issued, mmcm_rst
//     drops 64 cycles after RD_REQ, resp_err=1. Without the macro -> FSM stays in RD_WAIT.
//  6. Stray drdy in IDLE and in LOCK_WAIT -> no state change, no DRP access, no response.

Source files
------------

// File: rtl/mmcm_drp_reconfig_master.sv
// DRP read-modify-write master for one MMCME2 register, with MMCM reset and relock sequencing.
// Optional drdy/lock timeouts with a sticky error flag are enabled by defining MMCM_DRP_TIMEOUT_EN.
module mmcm_drp_reconfig_master #(
   parameter int ADDR_W       = 7,
   parameter int DATA_W       = 16,
   parameter int DRDY_TIMEOUT = 64,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic              clkin_int,
   input  logic              reset_int,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   input  logic [DATA_W-1:0] req_mask,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] drp_daddr,
   output logic              drp_den,
   output logic              drp_dwe,
   output logic [DATA_W-1:0] drp_di,
   input  logic [DATA_W-1:0] drp_do,
   input  logic              drp_drdy,
   output logic              mmcm_rst,
   input  logic              mmcm_locked
);
   // state | meaning
   // IDLE ready | ASSERT_RST reset MMCM | RD_REQ/RD_WAIT read access | WR_REQ/WR_WAIT write access
   // RELEASE 2-cycle reset release | LOCK_WAIT wait LOCKED | DONE response pulse
   typedef enum logic [3:0] {
      S_IDLE, S_ASSERT_RST, S_RD_REQ, S_RD_WAIT, S_WR_REQ,
      S_WR_WAIT, S_RELEASE, S_LOCK_WAIT, S_DONE
   } state_t;

   localparam int CW = $clog2(((DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT) + 1);
   localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q, mask_q, rd_q, rdata_q;
   logic              rel_q;
   logic              accept, rd_capture;
   logic              drdy_expired, lock_expired;

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      mmcm_rst   = 1'b0;
      drp_den    = 1'b0;
      drp_dwe    = 1'b0;
      drp_daddr  = '0;
      drp_di     = '0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      rd_capture = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = S_ASSERT_RST;
            end
         end
         S_ASSERT_RST: begin
            mmcm_rst  = 1'b1;
            state_nxt = S_RD_REQ;
         end
         S_RD_REQ: begin
            mmcm_rst  = 1'b1;
            drp_den   = 1'b1;
            drp_daddr = addr_q;
            if (drp_drdy) begin
               rd_capture = 1'b1;
               state_nxt  = S_WR_REQ;
            end else begin
               state_nxt = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            mmcm_rst  = 1'b1;
            drp_daddr = addr_q;
            if (drp_drdy) begin
               rd_capture = 1'b1;
               state_nxt  = S_WR_REQ;
            end else if (drdy_expired) begin
               state_nxt = S_RELEASE;
            end
         end
         S_WR_REQ: begin
            mmcm_rst  = 1'b1;
            drp_den   = 1'b1;
            drp_dwe   = 1'b1;
            drp_daddr = addr_q;
            drp_di    = (rd_q & mask_q) | (data_q & ~mask_q);
            state_nxt = drp_drdy ? S_RELEASE : S_WR_WAIT;
         end
         S_WR_WAIT: begin
            mmcm_rst  = 1'b1;
            drp_daddr = addr_q;
            if (drp_drdy || drdy_expired) state_nxt = S_RELEASE;
         end
         S_RELEASE: begin
            if (rel_q) state_nxt = S_LOCK_WAIT;
         end
         S_LOCK_WAIT: begin
            if (mmcm_locked || lock_expired) state_nxt = S_DONE;
         end
         S_DONE: begin
            resp_valid = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clkin_int or posedge reset_int) begin
      if (reset_int) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         mask_q  <= '0;
         rd_q    <= '0;
         rdata_q <= '0;
         rel_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         rel_q <= (state == S_RELEASE) && !rel_q;
         if (accept) begin
            addr_q <= req_addr;
            data_q <= req_data;
            mask_q <= req_mask;
            rd_q   <= '0;
         end else if (rd_capture) begin
            rd_q <= drp_do;
         end
         if (state_nxt == S_DONE && state != S_DONE) rdata_q <= rd_q;
      end
   end

   assign resp_rdata = rdata_q;

`ifdef MMCM_DRP_TIMEOUT_EN
   logic [CW-1:0] cnt_q;
   logic          err_q;
   logic          waiting;

   assign waiting      = (state == S_RD_WAIT) || (state == S_WR_WAIT) || (state == S_LOCK_WAIT);
   assign drdy_expired = (cnt_q == DRDY_LAST);
   assign lock_expired = (cnt_q == LOCK_LAST);

   always_ff @(posedge clkin_int or posedge reset_int) begin
      if (reset_int) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= (waiting && state_nxt == state) ? cnt_q + CW'(1) : '0;
         if (accept) begin
            err_q <= 1'b0;
         end else if (((state == S_RD_WAIT) || (state == S_WR_WAIT)) && !drp_drdy && drdy_expired) begin
            err_q <= 1'b1;
         end else if ((state == S_LOCK_WAIT) && !mmcm_locked && lock_expired) begin
            err_q <= 1'b1;
         end
      end
   end

   // Gated by DONE so the sticky flag never shows up outside the response pulse.
   assign resp_err = err_q && (state == S_DONE);
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^{DRDY_LAST, LOCK_LAST};
   assign drdy_expired       = 1'b0;
   assign lock_expired       = 1'b0;
   assign resp_err           = 1'b0;
`endif

endmodule

// File: tb/tb_mmcm_drp_reconfig_master.sv
// Bench for mmcm_drp_reconfig_master: transaction-level timeline model with randomized DRP/LOCKED timing.
// Honours MMCM_DRP_TIMEOUT_EN for the never-returning drdy case.
module tb_mmcm_drp_reconfig_master;
   localparam int AW = 7;
   localparam int DW = 16;

   logic          clkin_int = 1'b0;
   logic          reset_int;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data, req_mask;
   logic          resp_valid;
   logic [DW-1:0] resp_rdata;
   logic          resp_err;
   logic [AW-1:0] drp_daddr;
   logic          drp_den, drp_dwe;
   logic [DW-1:0] drp_di, drp_do;
   logic          drp_drdy;
   logic          mmcm_rst;
   logic          mmcm_locked;

   mmcm_drp_reconfig_master dut (
      .clkin_int(clkin_int), .reset_int(reset_int),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_data(req_data), .req_mask(req_mask),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
      .drp_do(drp_do), .drp_drdy(drp_drdy),
      .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
   );

   always #5 clkin_int = ~clkin_int;

   int            tests = 0;
   int            fails = 0;
   logic          exp_en = 1'b0;
   logic          exp_ready, exp_rst, exp_den, exp_dwe, exp_rv;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_di;
   logic [DW-1:0] exp_rdata = '0;
   logic [DW-1:0] mem [128];
   int            obs_resp_off;
   logic [DW-1:0] obs_wr_di, obs_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Single per-cycle compare against the expectations published by the stimulus tasks.
   initial forever begin
      @(negedge clkin_int);
      #1;
      if (exp_en && !reset_int) begin
         chk("req_ready", req_ready, exp_ready);
         chk("mmcm_rst", mmcm_rst, exp_rst);
         chk("drp_den", drp_den, exp_den);
         chk("drp_dwe", drp_dwe, exp_dwe);
         chk("drp_daddr", drp_daddr, exp_addr);
         chk("drp_di", drp_di, exp_di);
         chk("resp_valid", resp_valid, exp_rv);
         chk("resp_err", resp_err, 1'b0);
         chk("resp_rdata", resp_rdata, exp_rdata);
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clkin_int);
         req_valid   = 1'b0;
         req_addr    = AW'($urandom);
         req_data    = DW'($urandom);
         req_mask    = DW'($urandom);
         drp_drdy    = ($urandom_range(0, 3) == 0);
         drp_do      = DW'($urandom);
         mmcm_locked = 1'($urandom_range(0, 1));
         exp_en = 1'b1; exp_ready = 1'b1; exp_rst = 1'b0; exp_den = 1'b0; exp_dwe = 1'b0;
         exp_addr = '0; exp_di = '0; exp_rv = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      #1;
      reset_int = 1'b1;
      req_valid = 1'b0;
      drp_drdy  = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_mmcm_rst", mmcm_rst, 1'b0);
      chk("rst_den", drp_den, 1'b0);
      chk("rst_dwe", drp_dwe, 1'b0);
      chk("rst_daddr", drp_daddr, '0);
      chk("rst_di", drp_di, '0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_rdata", resp_rdata, '0);
      chk("rst_resp_err", resp_err, 1'b0);
      #1;
      reset_int = 1'b0;
      exp_rdata = '0;
   endtask

   // Offset 0 is the accept cycle; every later output is placed on the timeline by the rules:
   // read den at 2, drdy at 2+dr, write den right after, release 2 cycles, then wait for LOCKED.
   task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m,
                          input int dr, input int dw, input int lk, input int abort_at, input logic stray);
      int            w, r, dn;
      logic [DW-1:0] old, merged;
      w      = 3 + dr;
      r      = 4 + dr + dw;
      dn     = ((r + 2 > r + lk) ? r + 2 : r + lk) + 1;
      old    = mem[a];
      merged = (old & m) | (d & ~m);
      obs_resp_off = -1;
      obs_wr_di    = '0;
      obs_rdata    = '0;
      for (int o = 0; o <= dn; o++) begin
         @(negedge clkin_int);
         req_valid = (o == 0) ? 1'b1 : ((o < dn) ? 1'($urandom_range(0, 1)) : 1'b0);
         req_addr  = (o == 0) ? a : AW'($urandom);
         req_data  = (o == 0) ? d : DW'($urandom);
         req_mask  = (o == 0) ? m : DW'($urandom);
         drp_drdy  = (o == 2 + dr) || (o == w + dw) ||
                     (stray && (o < 2 || o > w + dw) && $urandom_range(0, 3) == 0);
         drp_do    = (o == 2 + dr) ? old : DW'($urandom);
         mmcm_locked = (o < r) ? 1'($urandom_range(0, 1)) : !(o < r + lk);
         exp_en    = 1'b1;
         exp_ready = (o == 0);
         exp_rst   = (o >= 1 && o < r);
         exp_den   = (o == 2 || o == w);
         exp_dwe   = (o == w);
         exp_addr  = (o >= 2 && o < r) ? a : '0;
         exp_di    = (o == w) ? merged : '0;
         exp_rv    = (o == dn);
         if (o == dn) exp_rdata = old;
         #1;
         if (resp_valid) begin
            obs_resp_off = o;
            obs_rdata    = resp_rdata;
         end
         if (drp_den && drp_dwe) obs_wr_di = drp_di;
         if (o == abort_at) begin
            pulse_reset();
            return;
         end
      end
      mem[a] = merged;
   endtask

`ifdef MMCM_DRP_TIMEOUT_EN
   task automatic timeout_txn();
      logic wr_seen   = 1'b0;
      logic resp_seen = 1'b0;
      logic err_seen  = 1'b0;
      @(negedge clkin_int);
      exp_en      = 1'b0;
      req_valid   = 1'b1;
      req_addr    = AW'($urandom);
      drp_drdy    = 1'b0;
      mmcm_locked = 1'b1;
      for (int o = 1; o < 300 && !resp_seen; o++) begin
         @(negedge clkin_int);
         req_valid = 1'b0;
         drp_drdy  = 1'b0;
         #1;
         if (drp_den && drp_dwe) wr_seen = 1'b1;
         if (resp_valid) begin
            resp_seen = 1'b1;
            err_seen  = resp_err;
         end
      end
      chk("timeout_no_write", wr_seen, 1'b0);
      chk("timeout_resp_seen", resp_seen, 1'b1);
      chk("timeout_resp_err", err_seen, 1'b1);
      exp_rdata = '0;
   endtask
`endif

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = DW'($urandom);
      reset_int   = 1'b1;
      req_valid   = 1'b0;
      req_addr    = '0;
      req_data    = '0;
      req_mask    = '0;
      drp_do      = '0;
      drp_drdy    = 1'b0;
      mmcm_locked = 1'b0;
      #3;
      chk("reset_req_ready", req_ready, 1'b1);
      chk("reset_mmcm_rst", mmcm_rst, 1'b0);
      chk("reset_den", drp_den, 1'b0);
      chk("reset_resp_valid", resp_valid, 1'b0);
      chk("reset_resp_rdata", resp_rdata, '0);
      @(negedge clkin_int);
      reset_int = 1'b0;
      idle(3);

      mem[8] = 16'h1234;
      run_txn(7'h08, 16'h00AB, 16'hFF00, 1, 1, 0, -1, 1'b0);
      chk("t1_write_di", obs_wr_di, 16'h12AB);
      chk("t1_resp_rdata", obs_rdata, 16'h1234);
      chk("t1_latency", obs_resp_off, 9);
      idle(2);

      mem[8] = 16'hBEEF;
      run_txn(7'h08, 16'h0F0F, 16'h00FF, 5, 5, 0, -1, 1'b0);
      chk("t2_write_di", obs_wr_di, 16'h0FEF);
      chk("t2_latency", obs_resp_off, 17);
      idle(1);

      run_txn(7'h21, 16'hAAAA, 16'h5555, 1, 1, 20, -1, 1'b0);
      chk("t3_latency", obs_resp_off, 27);
      idle(1);

      run_txn(7'h30, 16'h1111, 16'h0000, 5, 1, 0, 4, 1'b0);
      chk("t4_no_resp", obs_resp_off, -1);
      idle(2);
      run_txn(7'h30, 16'h2222, 16'h0000, 1, 1, 0, -1, 1'b0);
      chk("t4_recover_latency", obs_resp_off, 9);
      idle(1);

`ifdef MMCM_DRP_TIMEOUT_EN
      timeout_txn();
`else
      run_txn(7'h44, 16'h3333, 16'hF0F0, 200, 0, 0, 150, 1'b0);
      chk("t5_stuck_no_resp", obs_resp_off, -1);
`endif
      idle(3);

      for (int n = 0; n < 40; n++) begin
         run_txn(AW'($urandom_range(0, 127)), DW'($urandom), DW'($urandom),
                 $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 22), -1, 1'b1);
         idle($urandom_range(0, 3));
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end
endmodule
